// File: rtl/cpu_mem_bridge_if.sv
// Split-handshake memory bus (req / addr_ok / data_ok) between the bridge and the memory side.
// Handshake: an address phase completes on a cycle with bus_req=1 and bus_addr_ok=1; the data
// phase completes on the first cycle with bus_data_ok=1 at or after that; bus_rdata is valid with bus_data_ok.
interface cpu_mem_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              bus_req;
  logic              bus_wr;
  logic [BE_W-1:0]   bus_wstrb;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Bridge from the core's SRAM-style data port to the split-handshake bus, with kseg0/kseg1 translation.
// Optional watchdog enabled by defining CPU_MEM_BRIDGE_TIMEOUT_EN.
module cpu_mem_bridge #(
  parameter int       ADDR_W      = 32,
  parameter int       DATA_W      = 32,
  parameter logic [2:0] XLATE_MASK = 3'b111,
  parameter int       TIMEOUT_CYC = 1023,
  localparam int      BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [BE_W-1:0]   cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  cpu_mem_bridge_if.master  bus,
  output logic              bus_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              wr_q;
  logic [BE_W-1:0]   wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              complete;
  logic              timeout_hit;
  logic              to_fire;
  logic              bus_req_d;

  function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = a;
    if (a[ADDR_W-1 -: 3] == 3'b100 || a[ADDR_W-1 -: 3] == 3'b101)
      r[ADDR_W-1 -: 3] = a[ADDR_W-1 -: 3] & ~XLATE_MASK;
    return r;
  endfunction

  // Completion needs both phases; a data_ok seen in ADDR without addr_ok is ignored.
  assign complete = (state == ADDR && bus.bus_addr_ok && bus.bus_data_ok) ||
                    (state == DATA && bus.bus_data_ok);
  assign to_fire  = timeout_hit && !complete;

  always_comb begin
    state_d   = state;
    cpu_stall = 1'b0;
    bus_req_d = 1'b0;
    case (state)
      IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req) state_d = ADDR;
      end
      ADDR: begin
        cpu_stall = 1'b1;
        bus_req_d = 1'b1;
        if (complete || timeout_hit) state_d = DONE;
        else if (bus.bus_addr_ok)    state_d = DATA;
      end
      DATA: begin
        cpu_stall = 1'b1;
        if (complete || timeout_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && cpu_req) begin
        wr_q    <= cpu_wr;
        wstrb_q <= cpu_wr ? cpu_wen : {BE_W{1'b1}};
        addr_q  <= xlate(cpu_addr);
        wdata_q <= cpu_wdata;
      end
      if (complete && !wr_q)      rdata_q <= bus.bus_rdata;
      else if (to_fire && !wr_q)  rdata_q <= '1;
    end
  end

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  // Counter sits at 0 in IDLE, so it is clear on the first ADDR cycle; firing at TO_LAST
  // means it would reach TIMEOUT_CYC-1 on the edge that moves to DONE.
  assign timeout_hit = (state == ADDR || state == DATA) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_fire;
      if (state == ADDR || state == DATA) to_cnt <= to_cnt + CNT_W'(1);
      else                                to_cnt <= '0;
    end
  end

  assign bus_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

  assign bus.bus_req   = bus_req_d;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_wstrb = wstrb_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign cpu_rdata     = rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge: directed vector table, hand-written corner sequences and
// randomized accesses checked against a behavioural model of the bridge.
module tb_cpu_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req;
  logic          cpu_wr;
  logic [BW-1:0] cpu_wen;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          bus_err;
  logic [1:0]    state_dbg;

  cpu_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) mem ();

  cpu_mem_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .XLATE_MASK(3'b111), .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wr    (cpu_wr),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus       (mem.master),
    .bus_err   (bus_err),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // kseg0 / kseg1 (0x8000_0000 .. 0xBFFF_FFFF) map onto the low 512 MB.
  function automatic logic [AW-1:0] xlate_ref(input logic [AW-1:0] a);
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a - (a & 32'hE000_0000);
    return a;
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [BW-1:0] wen;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            aw;
    int            dw;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_wstrb;
  } vec_t;

  typedef struct {
    int            stall_cyc;
    int            req_cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] wstrb;
    logic          wr;
    logic [DW-1:0] rdata;
    logic          err;
    logic          req_at_done;
  } res_t;

  // ---------------- driver ----------------
  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the cycle after DONE.
  task automatic run_access(input vec_t v, output res_t r);
    int  a_cnt = 0;
    int  d_cnt = 0;
    bit  accepted = 0;
    bit  done = 0;
    r = '{default: 0};
    cpu_req   = 1'b1;
    cpu_wr    = v.wr;
    cpu_wen   = v.wen;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      mem.bus_addr_ok = 1'b0;
      mem.bus_data_ok = 1'b0;
      mem.bus_rdata   = $urandom();
      if (!cpu_stall) begin
        done          = 1;
        r.rdata       = cpu_rdata;
        r.err         = bus_err;
        r.req_at_done = mem.bus_req;
      end else begin
        r.stall_cyc++;
        if (mem.bus_req) begin
          if (r.req_cyc == 0) begin
            r.addr  = mem.bus_addr;
            r.wdata = mem.bus_wdata;
            r.wstrb = mem.bus_wstrb;
            r.wr    = mem.bus_wr;
          end
          r.req_cyc++;
          if (a_cnt == v.aw) begin
            mem.bus_addr_ok = 1'b1;
            accepted = 1;
            if (v.dw == 0) begin
              mem.bus_data_ok = 1'b1;
              mem.bus_rdata   = v.rdata;
            end
          end else begin
            a_cnt++;
          end
        end else if (accepted) begin
          d_cnt++;
          if (d_cnt == v.dw) begin
            mem.bus_data_ok = 1'b1;
            mem.bus_rdata   = v.rdata;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_bound: got no DONE within 300 cycles, required DONE");
    end
    mem.bus_addr_ok = 1'b0;
    mem.bus_data_ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input vec_t v, input res_t r, input logic [DW-1:0] exp_rd);
    check({tag, "_stall_cycles"}, r.stall_cyc, 2 + v.aw + v.dw);
    check({tag, "_req_cycles"}, r.req_cyc, v.aw + 1);
    check({tag, "_bus_addr"}, r.addr, v.exp_addr);
    check({tag, "_bus_wstrb"}, r.wstrb, v.exp_wstrb);
    check({tag, "_bus_wr"}, r.wr, v.wr);
    check({tag, "_bus_wdata"}, r.wdata, v.wdata);
    check({tag, "_cpu_rdata"}, r.rdata, exp_rd);
    check({tag, "_bus_err"}, r.err, 1'b0);
    check({tag, "_req_in_done"}, r.req_at_done, 1'b0);
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    for (int g = 0; g < n; g++) begin
      cpu_req         = 1'b0;
      mem.bus_addr_ok = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem.bus_data_ok = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      mem.bus_rdata   = $urandom();
      #1;
      check("idle_stall", cpu_stall, 1'b0);
      check("idle_bus_req", mem.bus_req, 1'b0);
      check("idle_rdata", cpu_rdata, last_rd);
      @(negedge clk);
    end
    mem.bus_addr_ok = 1'b0;
    mem.bus_data_ok = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[7];
  vec_t v;
  res_t r;
  int   req_count;

  initial begin
    tbl[0] = '{32'h8000_0010, 1'b0, 4'h0, 32'h0,         32'hDEAD_BEEF, 0, 0, 32'h0000_0010, 4'hF};
    tbl[1] = '{32'hA000_0004, 1'b1, 4'h3, 32'h1234_5678, 32'h0,         2, 3, 32'h0000_0004, 4'h3};
    tbl[2] = '{32'h0040_0000, 1'b0, 4'h0, 32'h0,         32'h0BAD_F00D, 1, 1, 32'h0040_0000, 4'hF};
    tbl[3] = '{32'hBFC0_0000, 1'b0, 4'h5, 32'h0,         32'h1111_2222, 0, 2, 32'h1FC0_0000, 4'hF};
    tbl[4] = '{32'hC000_0008, 1'b1, 4'h8, 32'hCAFE_0001, 32'h0,         0, 0, 32'hC000_0008, 4'h8};
    tbl[5] = '{32'h7FFF_FFFC, 1'b0, 4'h0, 32'h0,         32'h3333_4444, 3, 0, 32'h7FFF_FFFC, 4'hF};
    tbl[6] = '{32'h9FFF_FFFF, 1'b1, 4'hF, 32'h5A5A_A5A5, 32'h0,         1, 0, 32'h1FFF_FFFF, 4'hF};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    mem.bus_addr_ok = 1'b0; mem.bus_data_ok = 1'b0; mem.bus_rdata = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", state_dbg, 2'd0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_bus_req", mem.bus_req, 1'b0);
    check("rst_bus_addr", mem.bus_addr, 32'h0);
    check("rst_bus_wstrb", mem.bus_wstrb, 4'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed table, one idle cycle between accesses.
    for (int i = 0; i < 7; i++) begin
      run_access(tbl[i], r);
      if (!tbl[i].wr) last_rd = tbl[i].rdata;
      check_result($sformatf("vec%0d", i), tbl[i], r, last_rd);
      idle_cycles(1, 1'b0);
    end

    // Back-to-back reads with cpu_req held across DONE: exactly one bus_req burst each.
    v = '{32'h8000_0100, 1'b0, 4'h0, 32'h0, 32'hAAAA_0001, 0, 0, 32'h0000_0100, 4'hF};
    run_access(v, r);
    last_rd = v.rdata;
    check_result("b2b0", v, r, last_rd);
    v = '{32'h8000_0104, 1'b0, 4'h0, 32'h0, 32'hAAAA_0002, 1, 1, 32'h0000_0104, 4'hF};
    run_access(v, r);
    last_rd = v.rdata;
    check_result("b2b1", v, r, last_rd);
    req_count = 0;
    cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem.bus_req) req_count++;
      @(negedge clk);
    end
    check("b2b_no_reissue", req_count, 0);

    // Reset while in DATA; a later data_ok must not touch cpu_rdata.
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_wen = '0; cpu_addr = 32'h8000_0020; cpu_wdata = 32'h0;
    @(negedge clk);
    mem.bus_addr_ok = 1'b1;
    mem.bus_rdata   = 32'h7777_7777;
    @(negedge clk);
    mem.bus_addr_ok = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("mid_state_data", state_dbg, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_state", state_dbg, 2'd0);
    check("mid_rst_stall", cpu_stall, 1'b0);
    check("mid_rst_bus_req", mem.bus_req, 1'b0);
    check("mid_rst_bus_addr", mem.bus_addr, 32'h0);
    check("mid_rst_bus_wdata", mem.bus_wdata, 32'h0);
    check("mid_rst_bus_wr", mem.bus_wr, 1'b0);
    check("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b0;
    mem.bus_data_ok = 1'b1;
    mem.bus_rdata   = 32'h5555_AAAA;
    @(negedge clk);
    mem.bus_data_ok = 1'b0;
    #1;
    check("late_data_ok_rdata", cpu_rdata, 32'h0);
    check("late_data_ok_state", state_dbg, 2'd0);
    last_rd = '0;
    @(negedge clk);

    // Randomized accesses with stray handshakes in idle gaps.
    for (int i = 0; i < 40; i++) begin
      int gap;
      v.addr  = {3'($urandom_range(0, 7)), 29'($urandom())};
      v.wr    = 1'($urandom_range(0, 1));
      v.wen   = 4'($urandom_range(1, 15));
      v.wdata = $urandom();
      v.rdata = $urandom();
      v.aw    = $urandom_range(0, 3);
      v.dw    = $urandom_range(0, 3);
      v.exp_addr  = xlate_ref(v.addr);
      v.exp_wstrb = v.wr ? v.wen : 4'hF;
      if (!v.wr) last_rd = v.rdata;
      exp_q.push_back(last_rd);
      run_access(v, r);
      check_result($sformatf("rnd%0d", i), v, r, exp_q.pop_front());
      gap = $urandom_range(0, 2);
      idle_cycles(gap, 1'b1);
    end
    idle_cycles(1, 1'b0);

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
    // Read that never gets addr_ok: watchdog completes it with all-ones data and one bus_err pulse.
    v = '{32'h8000_0200, 1'b0, 4'h0, 32'h0, 32'h0, 100, 0, 32'h0000_0200, 4'hF};
    run_access(v, r);
    check("to_stall_cycles", r.stall_cyc, TO);
    check("to_req_cycles", r.req_cyc, TO - 1);
    check("to_cpu_rdata", r.rdata, 32'hFFFF_FFFF);
    check("to_bus_err", r.err, 1'b1);
    cpu_req = 1'b0;
    mem.bus_data_ok = 1'b1;
    mem.bus_rdata   = 32'h0000_1234;
    #1;
    check("to_err_one_cycle", bus_err, 1'b0);
    @(negedge clk);
    mem.bus_data_ok = 1'b0;
    #1;
    check("to_late_rdata", cpu_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Parametrised successor to the fixed single-cycle SRAM hookup of the MIPS core's data port.
- Sits between the core's SRAM-style data port and an address/data split-handshake bus (sram-like: req / addr_ok / data_ok).
- Registers each CPU access and applies kseg0/kseg1 unmapped address translation.
- Drives a pipeline stall until the access completes, then returns read data.

Parameters:
- ADDR_W, 32, address width; must be ≥ 4.
- DATA_W, 32, data width; multiple of 8; byte-enable width BE_W = DATA_W/8.
- XLATE_MASK, 3'b111, which of the top 3 address bits are cleared when translation applies.
- TIMEOUT_CYC, 1023, watchdog limit in cycles; used only with the optional feature; ≥ 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request; held stable while cpu_stall=1
- cpu_wr  in  1  1 = store, 0 = load
- cpu_wen  in  BE_W  store byte enables; ignored for loads
- cpu_addr  in  ADDR_W  virtual address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid in DONE
- cpu_stall  out  1  freeze pipeline
- bus_req  out  1  bus request
- bus_wr  out  1  write flag
- bus_wstrb  out  BE_W  byte strobes; all ones for reads
- bus_addr  out  ADDR_W  physical address
- bus_wdata  out  DATA_W  write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  data phase complete
- bus_rdata  in  DATA_W  read data, valid with bus_data_ok
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, ADDR, DATA, DONE. Reset → IDLE.
- Reset values: all outputs 0; cpu_rdata = 0; internal address/data registers = 0.
- IDLE:
  - cpu_req=1 → latch wr, wen, translated addr and wdata; go to ADDR.
  - cpu_stall = cpu_req (combinational).
- ADDR:
  - bus_req=1; bus_* driven from the latched registers.
  - bus_addr_ok=1 and bus_data_ok=1 in the same cycle → DONE.
  - bus_addr_ok=1 only → DATA.
  - Otherwise hold in ADDR.
  - cpu_stall=1.
- DATA:
  - bus_req=0; wait for bus_data_ok → DONE.
  - cpu_stall=1.
- Read data capture: bus_rdata is captured into cpu_rdata on the bus_data_ok edge for reads. cpu_rdata is unchanged by writes.
- DONE:
  - cpu_stall=0 for exactly one cycle; the pipeline advances.
  - Always → IDLE. A cpu_req present in DONE is the access being completed and is not re-issued.
  - cpu_rdata holds until the next read completes.
- Latency: minimum 2 stall cycles (IDLE, ADDR with combined ok), then DONE. Back-to-back accesses cost 3 cycles each minimum.
- Translation: if addr[ADDR_W-1:ADDR_W-3] is 3'b100 or 3'b101, the top 3 bits are ANDed with ~XLATE_MASK. Otherwise the address passes unchanged. Default: 0x8000_1000 → 0x0000_1000, 0xBFC0_0000 → 0x1FC0_0000, 0x0040_0000 unchanged.
- Stray handshakes: bus_addr_ok outside ADDR is ignored. bus_data_ok outside ADDR/DATA is ignored.
- Reset mid-transaction: any state → IDLE on the next edge; bus_req drops; any outstanding bus response afterwards is ignored.
- bus_err: 0 when the optional feature is absent.

Optional Feature:
- Macro: CPU_MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ADDR and increments each cycle in ADDR or DATA.
  - When it reaches TIMEOUT_CYC−1 without completion, the FSM goes to DONE.
  - For reads, cpu_rdata = all ones.
  - bus_err pulses 1 for that one cycle.
  - A late bus_data_ok is then ignored.
- Undefined: no counter; the bridge waits indefinitely; bus_err is tied 0.

Test Plan:
- Read at 0x8000_0010; addr_ok and data_ok both arrive in the ADDR cycle with rdata 0xDEAD_BEEF → bus_addr=0x0000_0010, bus_wstrb=4'hF; stall high 2 cycles; DONE cycle cpu_rdata=0xDEAD_BEEF, stall=0.
- Store at 0xA000_0004, wen=4'b0011, wdata=0x1234_5678; addr_ok after 2 wait cycles, data_ok 3 cycles later → bus_wr=1, bus_addr=0x0000_0004, bus_wstrb=4'b0011; bus_req high only in ADDR cycles; stall drops in the DONE cycle; cpu_rdata unchanged.
- Address 0x0040_0000 → bus_addr=0x0040_0000 (no translation).
- Two back-to-back reads with cpu_req held continuously → exactly two bus_req assertions; no duplicate issue in DONE.
- rst asserted during DATA → next cycle IDLE, all outputs 0; a subsequent bus_data_ok does not alter cpu_rdata.
- With CPU_MEM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYC=8, read with no addr_ok → after 8 stall cycles, DONE with cpu_rdata=0xFFFF_FFFF and bus_err=1 for one cycle.
